psram_cmd_sequencer: RTL
========================

# psram_cmd_sequencer

Sequences decoded UART commands onto the PSRAM controller and routes read data back to the UART transmitter. Sits between the UART receive/decode logic and the PSRAM controller. Provides:
- A small command queue, so back-to-back host commands are not lost while a PSRAM access is in flight.
- A single-outstanding request/done handshake toward the PSRAM controller.
- A completion timeout.
- Return of read results to the UART transmitter.

## Interface
Parameters:
- FIFO_DEPTH, 4: command queue entries; power of two, minimum 2.
- TIMEOUT_CYCLES, 4096: maximum sys_clk cycles from psram_start to psram_done.

Ports (name, direction, width, meaning):
- Clock and reset: one clock; reset is asynchronous and active-low.
  - sys_clk, in, 1: system clock (27 MHz); all logic is on its rising edge.
  - sys_rst_n, in, 1: asynchronous, active-low reset.
- Command input:
  - cmd_valid, in, 1: single-cycle pulse; a new decoded command is present.
  - cmd_rw, in, 2: 1 = write, 2 = read; 0 and 3 are invalid.
  - cmd_addr, in, 23: PSRAM word address.
  - cmd_wdata, in, 16: write data; ignored for reads.
  - cmd_drop, out, 1: one-cycle pulse; the command was rejected (queue full or invalid cmd_rw).
- PSRAM controller:
  - psram_start, out, 1: one-cycle request pulse.
  - psram_rd, out, 1: 1 = read, 0 = write; valid with psram_start and held until the next issue.
  - psram_addr, out, 23: access address; same validity as psram_rd.
  - psram_wdata, out, 16: write data; same validity as psram_rd.
  - psram_busy, in, 1: controller not ready; no psram_start may be issued while it is high.
  - psram_done, in, 1: one-cycle completion pulse.
  - psram_rdata, in, 16: read data; valid in the psram_done cycle.
- UART transmitter:
  - uart_send, out, 1: one-cycle pulse requesting transmission of uart_msg.
  - uart_msg, out, 16: read result; held stable until the next read completes.
  - uart_busy, in, 1: transmitter active.
- Status:
  - timeout_err, out, 1: sticky; set on timeout, cleared only by reset.
  - seq_idle, out, 1: high when the queue is empty and the FSM is in S_IDLE.

## Operation
- Reset values:
  - All outputs 0, except seq_idle = 1.
  - Queue empty; FSM in S_IDLE.
- Queue entry is {rd, addr, wdata}, 40 bits.
- Push: when cmd_valid is high, cmd_rw is 1 or 2, and the queue is not full.
- Otherwise, any cmd_valid pulse produces a cmd_drop pulse.
- FSM states:
  - S_IDLE: if the queue is not empty and psram_busy is 0, pop the head, register it onto the psram_* outputs, go to S_ISSUE.
  - S_ISSUE: psram_start = 1 for this single cycle; clear the timeout counter; go to S_WAIT.
  - S_WAIT: increment the timeout counter.
    - On psram_done with a read: latch psram_rdata into uart_msg, go to S_TX_REQ.
    - On psram_done with a write: go to S_IDLE.
    - If the counter reaches TIMEOUT_CYCLES - 1 without psram_done: set timeout_err, discard the command, go to S_IDLE.
  - S_TX_REQ: wait while uart_busy = 1. When uart_busy = 0, pulse uart_send and go to S_TX_HOLD.
  - S_TX_HOLD: one guard cycle, then wait until uart_busy = 0; go to S_IDLE.
- Only one PSRAM access is outstanding at a time. Queue order is preserved (FIFO).
- Timeout counter width is clog2(TIMEOUT_CYCLES). Queue pointers are clog2(FIFO_DEPTH) bits and wrap naturally; occupancy count is clog2(FIFO_DEPTH)+1 bits.

## Timing
- Latency: cmd_valid on a non-empty-capable idle path (queue empty, S_IDLE, psram_busy = 0):
  - cycle 0: push.
  - cycle 1: pop; FSM sees the queue not empty.
  - cycle 2: psram_start.
  - psram_start is therefore 2 cycles after cmd_valid.
- psram_done to uart_send: minimum 2 cycles (latch, then S_TX_REQ).
- Simultaneous push and pop:
  - With the queue full: the pop frees the slot only on the next edge, so the push is dropped (cmd_drop pulses).
  - Otherwise: both occur; occupancy is unchanged.
- Queue full: further commands are dropped; no entry is overwritten.
- psram_done outside S_WAIT: ignored.
- psram_done in the same cycle the counter hits its limit: done wins; no timeout.
- sys_rst_n asserted mid-operation: immediate return to reset values; the queue is flushed; pending UART data is lost.

## Structure
- Shared package psram_pkg holds:
  - command codes CMD_WRITE = 2'd1 and CMD_READ = 2'd2;
  - the address width 23 and data width 16;
  - the FSM state encoding.
- The queue is one sub-module, cmd_fifo (parameters WIDTH and DEPTH; ports push, pop, din, dout, full, empty). It uses first-word-fall-through dout.
- The FSM and timeout counter live in the top level.

## Test plan
1. Write then read: push W at 0x000010 with data 0xBEEF, then R at 0x000010. Required:
   - the psram outputs show rd = 0, 0x000010, 0xBEEF, then rd = 1, 0x000010;
   - model returns 0xBEEF with the read's psram_done;
   - one uart_send with uart_msg = 0xBEEF.
2. Queue full: hold psram_busy = 1 and push 5 commands. Required:
   - the 5th produces cmd_drop;
   - after psram_busy is released, exactly 4 accesses are issued, in push order.
3. Invalid command: cmd_rw = 3 with cmd_valid. Required: cmd_drop pulses; no push; seq_idle stays 1.
4. Timeout: issue a read with psram_done never returned (TIMEOUT_CYCLES = 16). Required:
   - timeout_err is set 16 cycles after psram_start;
   - no uart_send;
   - the next queued command is issued.
5. UART backpressure: read completes while uart_busy = 1 for 100 cycles. Required: uart_send occurs the cycle after uart_busy falls; uart_msg is held.
6. Async reset: assert sys_rst_n low while in S_WAIT with 2 entries queued. Required:
   - all outputs go to reset values immediately;
   - after release, no psram_start occurs until a new cmd_valid.

Source files
------------

// File: rtl/psram_pkg.sv
// Shared constants and FSM encoding for the PSRAM command sequencer.
package psram_pkg;
    localparam int ADDR_W  = 23;
    localparam int DATA_W  = 16;
    localparam int ENTRY_W = 1 + ADDR_W + DATA_W;

    localparam logic [1:0] CMD_WRITE = 2'd1;
    localparam logic [1:0] CMD_READ  = 2'd2;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ISSUE   = 3'd1,
        S_WAIT    = 3'd2,
        S_TX_REQ  = 3'd3,
        S_TX_HOLD = 3'd4
    } state_t;
endpackage

// File: rtl/cmd_fifo.sv
// First-word-fall-through command queue; pointers wrap naturally (DEPTH is a power of two).
module cmd_fifo #(
    parameter int WIDTH = 40,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);
    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [PW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == (PW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end
endmodule

// File: rtl/psram_cmd_sequencer.sv
// Queues decoded UART commands, issues them one at a time to the PSRAM controller,
// and forwards read results to the UART transmitter.
module psram_cmd_sequencer
    import psram_pkg::*;
#(
    parameter int FIFO_DEPTH     = 4,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic              sys_clk,
    input  logic              sys_rst_n,
    input  logic              cmd_valid,
    input  logic [1:0]        cmd_rw,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              cmd_drop,
    output logic              psram_start,
    output logic              psram_rd,
    output logic [ADDR_W-1:0] psram_addr,
    output logic [DATA_W-1:0] psram_wdata,
    input  logic              psram_busy,
    input  logic              psram_done,
    input  logic [DATA_W-1:0] psram_rdata,
    output logic              uart_send,
    output logic [DATA_W-1:0] uart_msg,
    input  logic              uart_busy,
    output logic              timeout_err,
    output logic              seq_idle,
    output state_t            dbg_state
);
    localparam int CW = $clog2(TIMEOUT_CYCLES);
    // Last increment lands the counter on TIMEOUT_CYCLES-1 and flags the timeout.
    localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT_CYCLES - 2);

    state_t             state;
    logic [CW-1:0]      tmo_cnt;
    logic               tx_guard;
    logic               cmd_ok;
    logic               push;
    logic               pop;
    logic               full;
    logic               empty;
    logic [ENTRY_W-1:0] head;

    assign cmd_ok    = (cmd_rw == CMD_WRITE) || (cmd_rw == CMD_READ);
    assign push      = cmd_valid && cmd_ok && !full;
    assign pop       = (state == S_IDLE) && !empty && !psram_busy;
    assign seq_idle  = empty && (state == S_IDLE);
    assign dbg_state = state;

    cmd_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (sys_clk),
        .rst_n (sys_rst_n),
        .push  (push),
        .pop   (pop),
        .din   ({cmd_rw == CMD_READ, cmd_addr, cmd_wdata}),
        .dout  (head),
        .full  (full),
        .empty (empty)
    );

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            cmd_drop <= 1'b0;
        end else begin
            cmd_drop <= cmd_valid && !push;
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state       <= S_IDLE;
            tmo_cnt     <= '0;
            tx_guard    <= 1'b0;
            psram_start <= 1'b0;
            psram_rd    <= 1'b0;
            psram_addr  <= '0;
            psram_wdata <= '0;
            uart_send   <= 1'b0;
            uart_msg    <= '0;
            timeout_err <= 1'b0;
        end else begin
            psram_start <= 1'b0;
            uart_send   <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (pop) begin
                        {psram_rd, psram_addr, psram_wdata} <= head;
                        psram_start <= 1'b1;
                        state       <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    tmo_cnt <= '0;
                    state   <= S_WAIT;
                end
                S_WAIT: begin
                    // A done arriving on the final count takes priority over the timeout.
                    if (psram_done) begin
                        if (psram_rd) begin
                            uart_msg <= psram_rdata;
                            state    <= S_TX_REQ;
                        end else begin
                            state <= S_IDLE;
                        end
                    end else if (tmo_cnt == TMO_LAST) begin
                        tmo_cnt     <= tmo_cnt + 1'b1;
                        timeout_err <= 1'b1;
                        state       <= S_IDLE;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end
                S_TX_REQ: begin
                    if (!uart_busy) begin
                        uart_send <= 1'b1;
                        tx_guard  <= 1'b1;
                        state     <= S_TX_HOLD;
                    end
                end
                S_TX_HOLD: begin
                    // The transmitter may only raise busy a cycle after uart_send.
                    if (tx_guard) begin
                        tx_guard <= 1'b0;
                    end else if (!uart_busy) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule
